btn_conditioner: RTL and testbench

Input-conditioning stage sitting directly upstream of the LED top level: it receives the raw, asynchronous push-button lines from the board (or VIO), synchronizes them to the system clock, debounces each one independently, and delivers clean levels plus single-cycle edge pulses. Its `o_btn` output replaces the raw `i_btn` currently fed to the top level. Its `o_rise` output lets the mode counter and the colour selector consume one event per press without their own previous-state registers.

---
 rtl/btn_conditioner_pkg.sv | 41 ++++
 rtl/btn_debounce_ch.sv | 61 ++++++
 rtl/btn_conditioner.sv | 44 ++++
 tb/tb_btn_conditioner.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/btn_conditioner_pkg.sv
// rtl/btn_conditioner_pkg.sv - shared board constants and event types for button conditioning
//
// Purpose: board-level constants (clock rate, debounce window, counter width)
//          and the per-channel event bundle passed from each debounce channel
//          to the top level.
// Ports:   none (package).
package btn_conditioner_pkg;

  localparam int unsigned CLK_FREQ_HZ           = 100_000_000;
  localparam int unsigned DEBOUNCE_MS           = 10;
  localparam int unsigned STABLE_CYCLES_DEFAULT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
  localparam int unsigned N_COUNT_DEFAULT       = 20;
  localparam int unsigned N_BTN_DEFAULT         = 4;

  // Registered outputs of one channel: debounced level plus its edge pulses.
  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } btn_evt_t;

  // Level unchanged this cycle: no pulses.
  function automatic btn_evt_t evt_hold(input logic level);
    btn_evt_t e;
    e.level = level;
    e.rise  = 1'b0;
    e.fall  = 1'b0;
    return e;
  endfunction

  // Level settles to new_level this cycle. Rise and fall are mutually
  // exclusive by construction.
  function automatic btn_evt_t evt_settle(input logic new_level);
    btn_evt_t e;
    e.level = new_level;
    e.rise  = new_level;
    e.fall  = ~new_level;
    return e;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: synchronizer, stability counter, level and pulses
//
// Purpose: brings one raw button line into the i_clk domain and only lets
//          the debounced level follow it after STABLE_CYCLES consecutive
//          clocks of disagreement.
// Ports:   i_clk   - system clock
//          i_reset - asynchronous active-low reset
//          i_btn   - raw button line (asynchronous)
//          o_evt   - registered {level, rise, fall}
module btn_debounce_ch
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned n_COUNT       = N_COUNT_DEFAULT,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic     i_clk,
  input  logic     i_reset,
  input  logic     i_btn,
  output btn_evt_t o_evt
);

  localparam logic [n_COUNT-1:0] LAST_COUNT = n_COUNT'(STABLE_CYCLES - 1);

  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic [n_COUNT-1:0] count_q, count_d;
  btn_evt_t           evt_q,   evt_d;

  always_comb begin
    sync1_d = i_btn;
    sync2_d = sync1_q;
    count_d = '0;
    evt_d   = evt_hold(evt_q.level);
    // Any cycle where the synchronized input agrees with the level clears
    // the count, so a single-cycle glitch restarts the whole window.
    if (sync2_q != evt_q.level) begin
      if (count_q == LAST_COUNT) begin
        evt_d = evt_settle(sync2_q);
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      count_q <= '0;
      evt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      count_q <= count_d;
      evt_q   <= evt_d;
    end
  end

  assign o_evt = evt_q;

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - debounced levels and edge pulses for n_BTN push-buttons
//
// Purpose: n_BTN fully independent debounce channels feeding the LED top
//          level with clean levels and one-cycle press/release pulses.
// Ports:   i_clk   - system clock
//          i_reset - asynchronous active-low reset
//          i_btn   - raw button lines [n_BTN-1:0]
//          o_btn   - debounced levels
//          o_rise  - one-cycle pulse on 0->1 of o_btn
//          o_fall  - one-cycle pulse on 1->0 of o_btn
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned n_BTN         = N_BTN_DEFAULT,
  parameter int unsigned n_COUNT       = N_COUNT_DEFAULT,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [n_BTN-1:0] i_btn,
  output logic [n_BTN-1:0] o_btn,
  output logic [n_BTN-1:0] o_rise,
  output logic [n_BTN-1:0] o_fall
);

  for (genvar g = 0; g < int'(n_BTN); g++) begin : g_ch
    btn_evt_t evt;

    btn_debounce_ch #(
      .n_COUNT      (n_COUNT),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_btn  (i_btn[g]),
      .o_evt  (evt)
    );

    assign o_btn[g]  = evt.level;
    assign o_rise[g] = evt.rise;
    assign o_fall[g] = evt.fall;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - table-driven scoreboard bench for btn_conditioner
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic [3:0] o_btn, o_rise, o_fall;

  btn_conditioner #(
    .n_BTN        (4),
    .n_COUNT      (3),
    .STABLE_CYCLES(4)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .i_btn  (btn),
    .o_btn  (o_btn),
    .o_rise (o_rise),
    .o_fall (o_fall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    logic [3:0] eb;
    logic [3:0] er;
    logic [3:0] ef;
  } vec_t;

  vec_t        tbl[$];
  logic [11:0] sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          vec_no   = 0;

  task automatic add(input logic r, input logic [3:0] b, input logic [3:0] eb,
                     input logic [3:0] er, input logic [3:0] ef, input int reps);
    vec_t v;
    v.rst = r; v.btn = b; v.eb = eb; v.er = er; v.ef = ef;
    for (int i = 0; i < reps; i++) tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec %0d: got %b expected %b", name, vec_no, act, exp);
  endtask

  // Drive each vector at negedge, push its expectation, and compare the
  // popped expectation against the outputs just after the following posedge.
  task automatic run_table();
    logic [11:0] e;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n = tbl[i].rst;
      btn   = tbl[i].btn;
      sb.push_back({tbl[i].eb, tbl[i].er, tbl[i].ef});
      @(posedge clk);
      #1;
      vec_no++;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard vec %0d: queue empty, expected one entry", vec_no);
      end else begin
        e = sb.pop_front();
        check("o_btn",  o_btn,  e[11:8]);
        check("o_rise", o_rise, e[7:4]);
        check("o_fall", o_fall, e[3:0]);
      end
    end
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    btn   = 4'b1111;
    #2;
    check("reset_o_btn",  o_btn,  4'b0000);
    check("reset_o_rise", o_rise, 4'b0000);
    check("reset_o_fall", o_fall, 4'b0000);

    // Reset held with all buttons down, then release: fresh press at edge 6.
    add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 2);
    add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 5);
    add(1, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1);
    add(1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1);
    add(1, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 5);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    // Clean press and release on channel 0.
    add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 5);
    add(1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1);
    add(1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1);
    add(1, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 5);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    // Bounce on channel 1: single rise 6 edges after the last 0->1.
    add(1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    add(1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    add(1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 5);
    add(1, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 1);
    add(1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1);
    add(1, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 5);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    // Channel 2: 3-cycle pulse is rejected, 4-cycle pulse just passes.
    add(1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 3);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 7);
    add(1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    add(1, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 1);
    add(1, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 3);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    // Channel 3: reset two counts into RISING, release with button held.
    add(1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4);
    add(0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 2);
    add(1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 5);
    add(1, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 1);
    add(1, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 1);
    run_table();

    // Asynchronous clear: o_btn[3] is high here; reset mid-cycle must
    // clear outputs without waiting for a clock edge.
    @(negedge clk);
    check("pre_async_o_btn", o_btn, 4'b1000);
    #1;
    rst_n = 1'b0;
    btn   = 4'b0000;
    #1;
    check("async_o_btn",  o_btn,  4'b0000);
    check("async_o_rise", o_rise, 4'b0000);
    check("async_o_fall", o_fall, 4'b0000);

    // Simultaneous press and release on channels 0 and 2.
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    add(1, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 5);
    add(1, 4'b0101, 4'b0101, 4'b0101, 4'b0000, 1);
    add(1, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1);
    add(1, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 5);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 1);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    run_table();

    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
